// File: rtl/gin_bus_controller.sv
// GIN bus segment sequencer: shifts MCC IDs into the chain, pulses the
// chain load, then forwards a fixed number of tagged packets onto the bus.
module gin_bus_controller #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 4,
  parameter int NUM_MCC    = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic [CNT_WIDTH-1:0]  cfg_len,
  input  logic [TAG_WIDTH-1:0]  cfg_id,
  input  logic                  cfg_id_valid,
  output logic [TAG_WIDTH-1:0]  id_shift_data,
  output logic                  id_shift_en,
  output logic                  id_load,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic [TAG_WIDTH-1:0]  src_tag,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic [TAG_WIDTH-1:0]  bus_tag,
  output logic                  bus_enable,
  input  logic                  bus_ready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  sent_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [15:0] LAST_ID = 16'(NUM_MCC - 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t               state;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] accepted_cnt;
  logic [15:0]          id_cnt;
  logic                 accept;
  logic                 complete;
  logic [CNT_WIDTH:0]   sent_next;

  assign src_ready = (state == S_RUN)
                   && (accepted_cnt < len_q)
                   && (!bus_enable || bus_ready);
  assign accept    = src_valid && src_ready;
  assign complete  = bus_enable && bus_ready;
  assign sent_next = {1'b0, sent_count}
                   + {{CNT_WIDTH{1'b0}}, complete};
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      len_q         <= '0;
      accepted_cnt  <= '0;
      id_cnt        <= '0;
      id_shift_data <= '0;
      id_shift_en   <= 1'b0;
      id_load       <= 1'b0;
      bus_data      <= '0;
      bus_tag       <= '0;
      bus_enable    <= 1'b0;
      done          <= 1'b0;
      sent_count    <= '0;
    end else begin
      id_shift_en <= 1'b0;
      id_load     <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cfg_start) begin
            len_q        <= cfg_len;
            id_cnt       <= '0;
            accepted_cnt <= '0;
            sent_count   <= '0;
            state        <= S_CONFIG;
          end
        end
        S_CONFIG: begin
          if (cfg_id_valid) begin
            id_shift_data <= cfg_id;
            id_shift_en   <= 1'b1;
            id_cnt        <= id_cnt + 16'd1;
            if (id_cnt == LAST_ID) state <= S_LOAD;
          end
        end
        // load strobe lands after the final shift so the chain is settled
        S_LOAD: begin
          id_load <= 1'b1;
          state   <= S_RUN;
        end
        S_RUN: begin
          if (accept) begin
            bus_data     <= src_data;
            bus_tag      <= src_tag;
            bus_enable   <= 1'b1;
            accepted_cnt <= accepted_cnt + ONE;
          end else if (complete) begin
            bus_data   <= '0;
            bus_tag    <= '0;
            bus_enable <= 1'b0;
          end
          if (complete) sent_count <= sent_count + ONE;
          if (sent_next == {1'b0, len_q}) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gin_bus_controller.sv
// Scoreboard bench for gin_bus_controller: driver pushes expected IDs and
// packets, a negedge monitor pops and checks them as the DUT emits them.
module tb_gin_bus_controller;

  localparam int DW = 64;
  localparam int TW = 4;
  localparam int N  = 12;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_start = 1'b0;
  logic [CW-1:0] cfg_len = '0;
  logic [TW-1:0] cfg_id = '0;
  logic          cfg_id_valid = 1'b0;
  logic [TW-1:0] id_shift_data;
  logic          id_shift_en;
  logic          id_load;
  logic [DW-1:0] src_data = '0;
  logic [TW-1:0] src_tag = '0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [DW-1:0] bus_data;
  logic [TW-1:0] bus_tag;
  logic          bus_enable;
  logic          bus_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [CW-1:0] sent_count;

  gin_bus_controller #(
    .DATA_WIDTH(DW),
    .TAG_WIDTH(TW),
    .NUM_MCC(N),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_start(cfg_start),
    .cfg_len(cfg_len),
    .cfg_id(cfg_id),
    .cfg_id_valid(cfg_id_valid),
    .id_shift_data(id_shift_data),
    .id_shift_en(id_shift_en),
    .id_load(id_load),
    .src_data(src_data),
    .src_tag(src_tag),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .bus_data(bus_data),
    .bus_tag(bus_tag),
    .bus_enable(bus_enable),
    .bus_ready(bus_ready),
    .busy(busy),
    .done(done),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
  } pkt_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [TW-1:0] exp_ids[$];
  pkt_t        exp_pkts[$];
  int          exp_len = 0;
  bit          run_full = 1'b0;
  int          ids_seen = 0;
  int          load_cyc = 0;
  int          cyc = 0;
  int          done_seen = 0;
  bit          prev_acc = 1'b0;
  bit          prev_stall = 1'b0;
  pkt_t        acc_p;
  pkt_t        stall_p;
  pkt_t        popped;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(string name, string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_acc   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_acc) begin
        chk("lat_en", DW'(bus_enable), 1);
        chk("lat_data", bus_data, acc_p.d);
        chk("lat_tag", DW'(bus_tag), DW'(acc_p.t));
      end
      if (prev_stall) begin
        chk("hold_en", DW'(bus_enable), 1);
        chk("hold_data", bus_data, stall_p.d);
        chk("hold_tag", DW'(bus_tag), DW'(stall_p.t));
      end
      if (!bus_enable) chk("idle_bus", bus_data | DW'(bus_tag), 0);
      if (bus_enable && !bus_ready) chk("stall_rdy", DW'(src_ready), 0);
      if (id_shift_en) begin
        if (exp_ids.size() == 0) fail("extra_id", "shift with no ID pending");
        else chk("id", DW'(id_shift_data), DW'(exp_ids.pop_front()));
        ids_seen++;
      end
      if (id_load) begin
        chk("load_ids", DW'(ids_seen), N);
        chk("load_excl", DW'(id_shift_en), 0);
        ids_seen = 0;
        load_cyc = cyc;
      end
      if (bus_enable && bus_ready) begin
        if (exp_pkts.size() == 0) fail("extra_pkt", "bus packet with none expected");
        else begin
          popped = exp_pkts.pop_front();
          chk("pkt_data", bus_data, popped.d);
          chk("pkt_tag", DW'(bus_tag), DW'(popped.t));
        end
      end
      if (done) begin
        chk("done_cnt", DW'(sent_count), DW'(exp_len));
        chk("done_left", DW'(exp_pkts.size()), 0);
        if (run_full) chk("done_lat", DW'(cyc - load_cyc), DW'(exp_len + 1));
        done_seen++;
      end
      prev_acc   = src_valid && src_ready;
      acc_p      = {src_data, src_tag};
      prev_stall = bus_enable && !bus_ready;
      stall_p    = {bus_data, bus_tag};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_data", bus_data, 0);
    chk("rst_ctl", DW'({id_shift_data, id_shift_en, id_load, src_ready,
                        bus_tag, bus_enable, busy, done, sent_count}), 0);
  endtask

  task automatic start_and_ids(int len, bit seq_ids, output pkt_t pk[$]);
    pkt_t p;
    bit   v;
    int   i;
    int   k;
    pk = {};
    for (int j = 0; j < len; j++) begin
      p.d = {$urandom, $urandom};
      p.t = TW'($urandom);
      pk.push_back(p);
      exp_pkts.push_back(p);
    end
    cfg_start = 1'b1;
    cfg_len   = CW'(len);
    tick();
    cfg_start = 1'b0;
    cfg_len   = CW'($urandom);
    i = 0;
    k = 0;
    while (i < N) begin
      v = seq_ids ? (k % 3 != 2) : ($urandom_range(0, 3) != 0);
      cfg_id_valid = v;
      cfg_id = seq_ids ? TW'(i) : TW'($urandom);
      if (v) begin
        exp_ids.push_back(cfg_id);
        i++;
      end
      k++;
      tick();
    end
    cfg_id_valid = 1'b0;
  endtask

  // mode 0: full rate, 1: random valid/ready, 2: 5-cycle stall on first packet
  task automatic transfer(int len, int mode, bit seq_ids, bit mid_start);
    pkt_t pk[$];
    pkt_t cur;
    int   idx;
    int   stall;
    int   t0;
    int   budget;
    exp_len  = len;
    run_full = (mode == 0);
    start_and_ids(len, seq_ids, pk);
    idx = 0;
    stall = 0;
    budget = 0;
    t0 = done_seen;
    while (done_seen == t0 && budget < 300) begin
      if (idx < len) cur = pk[idx];
      else begin
        cur.d = {$urandom, $urandom};
        cur.t = TW'($urandom);
      end
      src_data  = cur.d;
      src_tag   = cur.t;
      src_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mode == 0) bus_ready = 1'b1;
      else if (mode == 1) bus_ready = 1'($urandom_range(0, 1));
      else begin
        bus_ready = !(idx >= 1 && stall < 5);
        if (!bus_ready) stall++;
      end
      cfg_id_valid = 1'($urandom_range(0, 1));
      cfg_id       = TW'($urandom);
      cfg_start    = mid_start && (budget == 2);
      cfg_len      = CW'(len + 3);
      @(negedge clk);
      if (src_valid && src_ready) idx++;
      tick();
      budget++;
    end
    cfg_start    = 1'b0;
    src_valid    = 1'b0;
    cfg_id_valid = 1'b0;
    if (done_seen == t0) fail("timeout", "no done within 300 cycles");
    tick();
    tick();
  endtask

  task automatic abort_run();
    pkt_t pk[$];
    int   budget;
    bit   seen;
    exp_len  = 5;
    run_full = 1'b0;
    start_and_ids(5, 1'b0, pk);
    src_valid = 1'b1;
    src_data  = pk[0].d;
    src_tag   = pk[0].t;
    bus_ready = 1'b0;
    budget = 0;
    seen = 1'b0;
    while (!seen && budget < 40) begin
      @(negedge clk);
      seen = bus_enable;
      tick();
      budget++;
    end
    if (!seen) fail("abort_wait", "bus_enable never rose");
    reset = 1'b1;
    tick();
    chk_reset_outputs();
    reset     = 1'b0;
    src_valid = 1'b0;
    exp_pkts  = {};
    exp_ids   = {};
    ids_seen  = 0;
    tick();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    reset = 1'b0;
    tick();
    transfer(4, 0, 1'b1, 1'b0);
    transfer(3, 2, 1'b0, 1'b0);
    transfer(0, 0, 1'b0, 1'b0);
    transfer(4, 0, 1'b0, 1'b1);
    abort_run();
    transfer(6, 0, 1'b0, 1'b0);
    repeat (6) transfer($urandom_range(0, 12), 1, 1'b0, 1'b0);
    transfer(5, 1, 1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
